// File: rtl/avl_pio_pkg.sv
// Shared register-map and edge-mode constants for the multi-channel Avalon PIO.
package avl_pio_pkg;

  localparam logic [1:0] REG_DATA_OUT = 2'd0;
  localparam logic [1:0] REG_DATA_IN  = 2'd1;
  localparam logic [1:0] REG_EDGE_CAP = 2'd2;
  localparam logic [1:0] REG_IRQ_MASK = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  // Two register-select bits plus enough bits to index every channel.
  function automatic int unsigned addr_w(input int unsigned num_ch);
    return (num_ch <= 1) ? 2 : $clog2(num_ch) + 2;
  endfunction

endpackage

// File: rtl/pio_channel.sv
// One PIO channel: input synchroniser, edge detect/capture, output and IRQ-mask registers.
module pio_channel
  import avl_pio_pkg::*;
#(
  parameter int unsigned CH_WIDTH    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                wr_en,
  input  logic [1:0]          reg_sel,
  input  logic [3:0]          byte_en,
  input  logic [31:0]         wdata,
  input  logic [CH_WIDTH-1:0] pin,
  output logic [CH_WIDTH-1:0] data_out,
  output logic [CH_WIDTH-1:0] data_in,
  output logic [CH_WIDTH-1:0] edge_cap,
  output logic [CH_WIDTH-1:0] irq_mask,
  output logic                irq
);

  logic [CH_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CH_WIDTH-1:0] prev_q;
  logic [CH_WIDTH-1:0] out_q, cap_q, cap_d, mask_q;
  logic [CH_WIDTH-1:0] edge_det, lane_mask, wr_bits;
  logic [31:0]         lane_full, wr_full;
  logic                unused_hi;

  assign lane_full = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
  assign wr_full   = wdata & lane_full;
  assign lane_mask = lane_full[CH_WIDTH-1:0];
  assign wr_bits   = wr_full[CH_WIDTH-1:0];
  assign unused_hi = ^{wr_full, lane_full};

  always_comb begin
    edge_det = '0;
    if (EDGE_MODE == EDGE_RISE) begin
      edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    end else if (EDGE_MODE == EDGE_FALL) begin
      edge_det = ~sync_q[SYNC_STAGES-1] & prev_q;
    end else begin
      edge_det = sync_q[SYNC_STAGES-1] ^ prev_q;
    end
    if (!arm) edge_det = '0;
  end

  // A new edge beats a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    cap_d = cap_q;
    if (wr_en && reg_sel == REG_EDGE_CAP) cap_d = cap_q & ~wr_bits;
    cap_d = cap_d | edge_det;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      out_q  <= '0;
      cap_q  <= '0;
      mask_q <= '0;
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      cap_q  <= cap_d;
      if (wr_en && reg_sel == REG_DATA_OUT) out_q <= (out_q & ~lane_mask) | wr_bits;
      if (wr_en && reg_sel == REG_IRQ_MASK) mask_q <= (mask_q & ~lane_mask) | wr_bits;
    end
  end

  assign data_out = out_q;
  assign data_in  = sync_q[SYNC_STAGES-1];
  assign edge_cap = cap_q;
  assign irq_mask = mask_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: rtl/avl_multi_pio.sv
// Multi-channel Avalon-MM PIO slave: address decode, readdata mux, edge arming and IRQ.
module avl_multi_pio
  import avl_pio_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_WIDTH    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  localparam int unsigned ADDR_W     = addr_w(NUM_CH)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       AVL_CS,
  input  logic                       AVL_READ,
  input  logic                       AVL_WRITE,
  input  logic [ADDR_W-1:0]          AVL_ADDR,
  input  logic [3:0]                 AVL_BYTE_EN,
  input  logic [31:0]                AVL_WRITEDATA,
  output logic [31:0]                AVL_READDATA,
  input  logic [NUM_CH*CH_WIDTH-1:0] PIO_IN,
  output logic [NUM_CH*CH_WIDTH-1:0] PIO_OUT,
  output logic                       IRQ
);

  localparam int unsigned CH_W    = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;

  logic [CH_W-1:0]     ch_idx;
  logic [1:0]          reg_sel;
  logic [2:0]          arm_cnt_q;
  logic                armed;
  logic [31:0]         rd_val, rdata_q;
  logic                irq_q;
  logic [NUM_CH-1:0]   ch_irq;
  logic [CH_WIDTH-1:0] ch_out  [NUM_CH];
  logic [CH_WIDTH-1:0] ch_in   [NUM_CH];
  logic [CH_WIDTH-1:0] ch_cap  [NUM_CH];
  logic [CH_WIDTH-1:0] ch_mask [NUM_CH];

  if (ADDR_W > 2) begin : g_ch_idx
    assign ch_idx = AVL_ADDR[ADDR_W-1:2];
  end else begin : g_ch_idx_one
    assign ch_idx = '0;
  end
  assign reg_sel = AVL_ADDR[1:0];
  assign armed   = (arm_cnt_q == 3'(ARM_MAX));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pio_channel #(
      .CH_WIDTH    (CH_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
    ) u_ch (
      .clk      (CLK),
      .reset    (RESET),
      .arm      (armed),
      .wr_en    (AVL_CS && AVL_WRITE && (ch_idx == CH_W'(c))),
      .reg_sel  (reg_sel),
      .byte_en  (AVL_BYTE_EN),
      .wdata    (AVL_WRITEDATA),
      .pin      (PIO_IN[c*CH_WIDTH +: CH_WIDTH]),
      .data_out (ch_out[c]),
      .data_in  (ch_in[c]),
      .edge_cap (ch_cap[c]),
      .irq_mask (ch_mask[c]),
      .irq      (ch_irq[c])
    );
    assign PIO_OUT[c*CH_WIDTH +: CH_WIDTH] = ch_out[c];
  end

  // Channel indices beyond NUM_CH match no channel and therefore read as zero.
  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == CH_W'(c)) begin
        case (reg_sel)
          REG_DATA_OUT: rd_val = 32'(ch_out[c]);
          REG_DATA_IN:  rd_val = 32'(ch_in[c]);
          REG_EDGE_CAP: rd_val = 32'(ch_cap[c]);
          default:      rd_val = 32'(ch_mask[c]);
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      arm_cnt_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (!armed) arm_cnt_q <= arm_cnt_q + 3'd1;
      if (AVL_CS && AVL_READ) rdata_q <= rd_val;
      irq_q <= |ch_irq;
    end
  end

  assign AVL_READDATA = rdata_q;
  assign IRQ          = irq_q;

endmodule

// File: tb/tb_avl_multi_pio.sv
// Directed bench: a 4-channel rising-edge PIO and a 3-channel both-edge PIO on one shared bus.
module tb_avl_multi_pio;

  logic        clk = 1'b0;
  logic        rst, cs, rd, wr;
  logic [3:0]  addr, be;
  logic [31:0] wdata, rdata_a, rdata_b;
  logic [63:0] pin_a, pout_a;
  logic [47:0] pin_b, pout_b;
  logic        irq_a, irq_b;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  avl_multi_pio #(.NUM_CH(4), .CH_WIDTH(16), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
    .CLK (clk), .RESET (rst), .AVL_CS (cs), .AVL_READ (rd), .AVL_WRITE (wr),
    .AVL_ADDR (addr), .AVL_BYTE_EN (be), .AVL_WRITEDATA (wdata), .AVL_READDATA (rdata_a),
    .PIO_IN (pin_a), .PIO_OUT (pout_a), .IRQ (irq_a)
  );

  avl_multi_pio #(.NUM_CH(3), .CH_WIDTH(16), .SYNC_STAGES(2), .EDGE_MODE(2)) dut_b (
    .CLK (clk), .RESET (rst), .AVL_CS (cs), .AVL_READ (rd), .AVL_WRITE (wr),
    .AVL_ADDR (addr), .AVL_BYTE_EN (be), .AVL_WRITEDATA (wdata), .AVL_READDATA (rdata_b),
    .PIO_IN (pin_b), .PIO_OUT (pout_b), .IRQ (irq_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; be = b; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
    pin_a = '1; pin_b = '1;
    idle(3);
    rst = 1'b0;
    idle(8);

    // Inputs held high through reset must not look like edges.
    check_eq("rst_irq_a", irq_a, 0);
    check_eq("rst_irq_b", irq_b, 0);
    check_eq("rst_pout_a", pout_a, 0);
    check_eq("rst_rdata_a", rdata_a, 0);
    bus_read(4'h2);
    check_eq("rst_cap_a", rdata_a, 0);
    check_eq("rst_cap_b", rdata_b, 0);
    bus_read(4'h6);
    check_eq("rst_cap1_b", rdata_b, 0);

    // Falling inputs: ignored by the rising-only PIO, captured by the both-edge PIO.
    pin_a = '0; pin_b = '0;
    idle(5);
    bus_read(4'h2);
    check_eq("fall_ignored_a", rdata_a, 0);
    check_eq("fall_cap_b", rdata_b, 32'h0000_FFFF);
    for (int c = 0; c < 3; c++) bus_write(4'(c * 4 + 2), 4'hF, 32'hFFFF_FFFF);
    bus_read(4'h2);
    check_eq("cap_clr_b", rdata_b, 0);

    // Byte-enabled DATA_OUT write to channel 1.
    bus_write(4'h4, 4'b0011, 32'hDEAD_BEEF);
    check_eq("pout_ch1", pout_a[31:16], 16'hBEEF);
    check_eq("pout_ch0", pout_a[15:0], 16'h0000);
    bus_read(4'h4);
    check_eq("rd_ch1", rdata_a, 32'h0000_BEEF);
    bus_write(4'h4, 4'b0010, 32'h1234_5678);
    check_eq("rd_hold", rdata_a, 32'h0000_BEEF);
    check_eq("lane1", pout_a[31:16], 16'h56EF);

    // Rising edge on ch0 bit 0 with mask set.
    bus_write(4'h3, 4'hF, 32'h1);
    bus_read(4'h3);
    check_eq("mask_rd", rdata_a, 32'h1);
    pin_a[0] = 1'b1;
    n = 0;
    while (!irq_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("irq_rise", (n >= 1 && n <= 4), 1);
    bus_read(4'h2);
    check_eq("cap_ch0", rdata_a, 32'h1);
    bus_read(4'h2);
    check_eq("cap_sticky", rdata_a, 32'h1);
    check_eq("no_irq_b", irq_b, 0);
    bus_write(4'h2, 4'hF, 32'h1);
    check_eq("irq_hold", irq_a, 1);
    idle(1);
    check_eq("irq_drop", irq_a, 0);
    bus_read(4'h2);
    check_eq("cap_w1c", rdata_a, 0);

    // Edge arriving in the same cycle as a W1C of the already-set bit.
    pin_a[0] = 1'b0; idle(5);
    pin_a[0] = 1'b1; idle(5);
    check_eq("irq_re", irq_a, 1);
    pin_a[0] = 1'b0; idle(5);
    pin_a[0] = 1'b1; idle(2);
    bus_write(4'h2, 4'hF, 32'h1);
    check_eq("coll_irq", irq_a, 1);
    idle(1);
    check_eq("coll_irq2", irq_a, 1);
    bus_read(4'h2);
    check_eq("coll_cap", rdata_a, 32'h1);
    bus_write(4'h3, 4'hF, 32'h0);
    idle(1);
    check_eq("mask_drop", irq_a, 0);

    // Channel 3 exists only in the 4-channel PIO.
    bus_write(4'hC, 4'hF, 32'h0000_A5A5);
    bus_read(4'hC);
    check_eq("oob_rd_b", rdata_b, 0);
    check_eq("oob_rd_a", rdata_a, 32'h0000_A5A5);
    check_eq("oob_pout_b", pout_b, 48'h0000_56EF_0000);
    bus_read(4'h0);
    check_eq("oob_out0_b", rdata_b, 0);

    // Both-edge capture on ch0 bit 5 of the 3-channel PIO.
    pin_b[5] = 1'b1;
    idle(3);
    bus_read(4'h2);
    check_eq("both_rise", rdata_b, 32'h20);
    pin_b[5] = 1'b0;
    bus_write(4'h2, 4'hF, 32'h20);
    bus_read(4'h2);
    check_eq("both_clr", rdata_b, 0);
    idle(3);
    bus_read(4'h2);
    check_eq("both_fall", rdata_b, 32'h20);
    check_eq("both_irq_b", irq_b, 0);

    // Simultaneous read and write returns the pre-write value.
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'h0; be = 4'hF; wdata = 32'h1234;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    check_eq("rw_pre", rdata_a, 0);
    bus_read(4'h0);
    check_eq("rw_post", rdata_a, 32'h1234);

    // Reset during a read aborts it.
    cs = 1'b1; rd = 1'b1; addr = 4'h4; rst = 1'b1;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    check_eq("rst_rdata2", rdata_a, 0);
    check_eq("rst_pout2", pout_a, 0);
    rst = 1'b0;
    idle(1);
    check_eq("rst_irq2", irq_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
